// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit.
// The result is computed when the op starts and committed to HI/LO after a fixed busy time.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdu_en,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        op_valid;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_safe, abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [63:0] start_res;

  assign op_valid = (mdu_op >= OP_MULT) && (mdu_op <= OP_MTLO);

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  // b_safe keeps the dividers defined on B=0; that result is discarded anyway.
  assign b_safe = (B == 32'd0) ? 32'd1 : B;
  assign abs_a  = A[31] ? (32'd0 - A) : A;
  assign abs_b  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
  assign q_mag  = abs_a / abs_b;
  assign r_mag  = abs_a % abs_b;
  assign q_s    = (A[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s    = A[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u    = A / b_safe;
  assign r_u    = A % b_safe;

  always_comb begin
    start_res = {hi_q, lo_q};
    unique case (mdu_op)
      OP_MULT:  start_res = prod_s;
      OP_MULTU: start_res = prod_u;
      // Divide by zero commits the current HI/LO, so nothing visibly changes.
      OP_DIV:   if (B != 32'd0) start_res = {r_s, q_s};
      OP_DIVU:  if (B != 32'd0) start_res = {r_u, q_u};
      default:  start_res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (mdu_en) begin
          unique case (mdu_op)
            OP_MULT, OP_MULTU: begin
              res_d   = start_res;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_d   = start_res;
              cnt_d   = 4'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign stall_req = mdu_en && op_valid && busy;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mdu_out   = (mdu_op == OP_MFHI) ? hi_q :
                     (mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// checked against a transaction-level HI/LO model built on 64-bit arithmetic.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset, mdu_en, busy, stall_req;
  logic [3:0]  mdu_op;
  logic [31:0] A, B, hi, lo, mdu_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .mdu_en(mdu_en), .mdu_op(mdu_op), .A(A), .B(B),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int cyc_of(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  function automatic logic [31:0] exp_out(input logic [3:0] op);
    if (op == 4'd5) return m_hi;
    if (op == 4'd6) return m_lo;
    return 32'd0;
  endfunction

  // Architectural effect of an accepted op on HI/LO.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      4'd1: begin v = 64'(sa * sb); m_hi = v[63:32]; m_lo = v[31:0]; end
      4'd2: begin up = ua * ub; v = up; m_hi = v[63:32]; m_lo = v[31:0]; end
      4'd3: if (b != 32'd0) begin
        sq = sa / sb; sr = sa % sb;
        m_lo = 32'(sq); m_hi = 32'(sr);
      end
      4'd4: if (b != 32'd0) begin
        m_lo = 32'(ua / ub); m_hi = 32'(ua % ub);
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  // mode 0: quiet inputs while busy; 1: random ops while busy (must be ignored);
  // 2: mfhi held from the 2nd busy cycle on, checked again when busy drops.
  task automatic do_op(input string tag, input bit en, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input int mode);
    int  n;
    bit  ren;
    logic [3:0] rop;
    mdu_en = en; mdu_op = op; A = a; B = b;
    #1;
    chk({tag, ":stall_idle"}, stall_req, 0);
    chk({tag, ":out_idle"}, mdu_out, exp_out(op));
    @(posedge clk); #1;
    mdu_en = 1'b0; mdu_op = 4'd0;
    if (en) model_exec(op, a, b);
    if (en && cyc_of(op) != 0) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        ren = 1'b0; rop = 4'd0;
        if (mode == 1) begin
          ren = 1'($urandom_range(0, 1));
          rop = 4'($urandom_range(0, 15));
        end else if (mode == 2 && n >= 2) begin
          ren = 1'b1; rop = 4'd5;
        end
        mdu_en = ren; mdu_op = rop; A = $urandom; B = $urandom;
        #1;
        chk({tag, ":stall_busy"}, stall_req, ren && rop >= 4'd1 && rop <= 4'd8);
        @(posedge clk); #1;
      end
      chk({tag, ":busy_cycles"}, 64'(n), 64'(cyc_of(op)));
      if (mode == 2) begin
        chk({tag, ":stall_after"}, stall_req, 0);
        chk({tag, ":mfhi_after"}, mdu_out, m_hi);
      end
      mdu_en = 1'b0; mdu_op = 4'd0;
    end
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":hi"}, hi, m_hi);
    chk({tag, ":lo"}, lo, m_lo);
  endtask

  initial begin
    reset = 1'b1; mdu_en = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
    #12;
    chk("rst:busy", busy, 0);
    chk("rst:hi", hi, 0);
    chk("rst:lo", lo, 0);
    chk("rst:stall", stall_req, 0);
    chk("rst:out", mdu_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_op("mult", 1, 4'd1, 32'hFFFFFFFF, 32'd2, 0);
    chk("mult:hi_const", hi, 32'hFFFFFFFF);
    chk("mult:lo_const", lo, 32'hFFFFFFFE);
    do_op("multu", 1, 4'd2, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu:hi_const", hi, 32'h00000001);
    do_op("div", 1, 4'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div:lo_const", lo, 32'hFFFFFFFD);
    chk("div:hi_const", hi, 32'hFFFFFFFF);
    do_op("divu", 1, 4'd4, 32'd7, 32'd2, 0);
    chk("divu:lo_const", lo, 32'd3);
    chk("divu:hi_const", hi, 32'd1);
    do_op("ovf", 1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf:lo_const", lo, 32'h80000000);
    chk("ovf:hi_const", hi, 32'd0);

    do_op("mtlo0", 1, 4'd8, 32'd0, 32'd0, 0);
    do_op("mthi", 1, 4'd7, 32'h12345678, 32'd0, 0);
    do_op("mflo", 1, 4'd6, 32'd0, 32'd0, 0);
    do_op("mfhi", 1, 4'd5, 32'd0, 32'd0, 0);
    do_op("en0", 0, 4'd7, 32'hDEADBEEF, 32'd0, 0);
    do_op("op9", 1, 4'd9, 32'hDEADBEEF, 32'd1, 0);

    do_op("stallmul", 1, 4'd1, 32'h00012345, 32'hFFFF0003, 2);

    do_op("mthiA", 1, 4'd7, 32'hAAAA0000, 32'd0, 0);
    do_op("mtloB", 1, 4'd8, 32'h0000BBBB, 32'd0, 0);
    do_op("div0", 1, 4'd3, 32'h00001234, 32'd0, 1);
    chk("div0:hi_const", hi, 32'hAAAA0000);
    chk("div0:lo_const", lo, 32'h0000BBBB);

    // Abort a divide in its third busy cycle with an asynchronous reset.
    mdu_en = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    mdu_en = 1'b0; mdu_op = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("abort:busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:hi", hi, 0);
    chk("abort:lo", lo, 0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    do_op("postrst", 1, 4'd1, 32'd3, 32'd4, 0);
    chk("postrst:lo_const", lo, 32'd12);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      bit          ren;
      rop = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 3) != 0);
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
      do_op("rand", ren, rop, ra, rb, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu, in clk cycles.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu, in clk cycles.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mdu_en  input  1  E-stage instruction valid (not bubble, not stalled); ops are ignored when low.
REQ-006 mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-007 A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source).
REQ-008 B  input  32  operand rt (divisor / multiplier).
REQ-009 busy  output  1  registered; high while a mult/div is in flight.
REQ-010 stall_req  output  1  combinational; stall request to hazard unit.
REQ-011 hi  output  32  HI register value.
REQ-012 lo  output  32  LO register value.
REQ-013 mdu_out  output  32  combinational read data: hi when mdu_op=5, lo when mdu_op=6, else 0; carried down the pipeline to write-back.

Function
REQ-014 State: IDLE, RUN; 4-bit down-counter cnt; 64-bit pending result {res_hi,res_lo}.
REQ-015 IDLE, mdu_en=1, op in 1..4: on the edge, compute result from A/B, load pending result, load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), go RUN.
REQ-016 busy SHALL be 1 exactly when state=RUN; for mult, busy is high for 5 consecutive cycles following the start edge; for div, 10.
REQ-017 RUN: cnt decrements each edge; on the edge where cnt=1, hi/lo load pending result, state returns IDLE, busy drops; new hi/lo visible in the first cycle busy is low.
REQ-018 mult: signed 32x32 -> 64-bit product, {hi,lo}=product; multu: same, unsigned.
REQ-019 div: lo=signed quotient truncated toward zero, hi=remainder with sign of dividend; divu: unsigned.
REQ-020 Divide by zero (B=0): operation still runs DIV_CYCLES; hi and lo SHALL remain unchanged at completion.
REQ-021 Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-022 mthi/mtlo (ops 7,8), mdu_en=1, state IDLE: hi (resp. lo) loads A on that edge; the other register is unchanged.
REQ-023 Any op 1..8 arriving while state=RUN SHALL be ignored (no start, no write); the hazard unit holds it via stall_req.
REQ-024 stall_req = mdu_en and op in 1..8 and (busy=1); op 0/9-15 never stall.
REQ-025 mfhi/mflo during IDLE: mdu_out reflects current hi/lo combinationally, no state change.
REQ-026 mdu_en=0: no state change from mdu_op, regardless of op value; an in-flight operation still progresses.
REQ-027 hi, lo, busy SHALL be registered outputs; no combinational path from A/B to hi/lo.

Reset
REQ-028 reset=1 SHALL immediately (asynchronously) force state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending result=0.
REQ-029 Reset asserted mid-operation SHALL abort it; the result is never written; after release the unit accepts a new op on the first edge.
REQ-030 stall_req and mdu_out follow from reset state combinationally (stall_req=0 unless inputs request).

Verification
REQ-031 mult A=0xFFFFFFFF B=2 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-032 div A=0xFFFFFFF9 (-7) B=2 -> busy high 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; divu A=7 B=2 -> lo=3 hi=1.
REQ-033 mthi A=0x12345678 in IDLE, then mflo with lo=0 -> hi=0x12345678, mdu_out=0, no stall.
REQ-034 mult started, then mfhi presented in cycle 2 of busy -> stall_req=1 until busy drops, mdu_out=new hi in first non-busy cycle.
REQ-035 div with B=0 after hi=0xAAAA0000 lo=0x0000BBBB -> busy 10 cycles, hi/lo unchanged afterwards.
REQ-036 reset pulsed at cycle 3 of a div -> busy=0, hi=lo=0 immediately; a following mult A=3 B=4 completes to lo=12 hi=0.
